// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, default widths and
// the per-pipe request bundle.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 9;
    localparam int unsigned DMEM_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISS0,
        WT0,
        ISS1,
        WT1,
        DONE
    } dmem_state_t;

    typedef struct packed {
        logic                   req;
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Serialises the S3 memory accesses of pipes P0 and P1 onto the single-port
// data memory, P0 first, stalling both pipes until the pair has completed.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata
);

    dmem_state_t       state_q, state_d;
    logic              pend1_q, pend1_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    dmem_req_t         p0, p1;

    assign p0 = '{req: p0_req, we: p0_we, addr: p0_addr, wdata: p0_wdata};
    assign p1 = '{req: p1_req, we: p1_we, addr: p1_addr, wdata: p1_wdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend1_q    <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            pend1_q    <= pend1_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    // Memory-side outputs are decoded from state so reset silences them at once.
    always_comb begin
        state_d    = state_q;
        pend1_d    = pend1_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_stall  = 1'b0;

        unique case (state_q)
            IDLE: begin
                mem_stall = p0.req | p1.req;
                if (p0.req) begin
                    state_d = ISS0;
                    pend1_d = p1.req;
                end else if (p1.req) begin
                    state_d = ISS1;
                end
            end
            ISS0: begin
                mem_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = p0.we;
                mem_addr  = p0.addr;
                mem_wdata = p0.wdata;
                if (mem_gnt) begin
                    if (p0.we) state_d = pend1_q ? ISS1 : DONE;
                    else       state_d = WT0;
                end
            end
            WT0: begin
                mem_stall = 1'b1;
                if (mem_rvalid) begin
                    p0_rdata_d = mem_rdata;
                    state_d    = pend1_q ? ISS1 : DONE;
                end
            end
            ISS1: begin
                mem_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = p1.we;
                mem_addr  = p1.addr;
                mem_wdata = p1.wdata;
                if (mem_gnt) begin
                    if (p1.we) begin
                        state_d = DONE;
                        pend1_d = 1'b0;
                    end else begin
                        state_d = WT1;
                    end
                end
            end
            WT1: begin
                mem_stall = 1'b1;
                if (mem_rvalid) begin
                    p1_rdata_d = mem_rdata;
                    state_d    = DONE;
                    pend1_d    = 1'b0;
                end
            end
            // Requests seen here still belong to the pair that just finished.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: memory model plus a scoreboard of
// expected memory accesses, popped as the arbiter issues them.
module tb_dmem_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr, mem_addr;
    logic [DW-1:0] p0_wdata, p1_wdata, mem_wdata, mem_rdata, p0_rdata, p1_rdata;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid, mem_stall;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .p0_req     (p0_req),
        .p0_we      (p0_we),
        .p0_addr    (p0_addr),
        .p0_wdata   (p0_wdata),
        .p1_req     (p1_req),
        .p1_we      (p1_we),
        .p1_addr    (p1_addr),
        .p1_wdata   (p1_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_stall  (mem_stall),
        .p0_rdata   (p0_rdata),
        .p1_rdata   (p1_rdata)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    acc_t          exp_q[$];
    logic [DW-1:0] mem [0:511];
    int            errors = 0;
    int            checks = 0;
    int            gnt_hold = 0;
    int            wr_cnt = 0;
    bit            rd_pend = 1'b0;
    logic [DW-1:0] rd_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One memory cycle: deliver pending read data, check and grant any request.
    task automatic mem_respond();
        acc_t e;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (rd_pend) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd_data;
            rd_pend    = 1'b0;
        end
        if (mem_req) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_req", 32'(mem_req), 32'd0);
            end else begin
                e = exp_q[0];
                check_eq("mem_we", 32'(mem_we), 32'(e.we));
                check_eq("mem_addr", 32'(mem_addr), 32'(e.addr));
                check_eq("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
                if (gnt_hold > 0) begin
                    gnt_hold--;
                end else begin
                    mem_gnt = 1'b1;
                    void'(exp_q.pop_front());
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        wr_cnt++;
                    end else begin
                        rd_pend = 1'b1;
                        rd_data = mem[mem_addr];
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic r1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic push(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        acc_t e;
        e.we = we; e.addr = addr; e.wdata = wd;
        exp_q.push_back(e);
    endtask

    // Runs the current request pair until the stall drops (DONE), counting stall cycles.
    task automatic run_pair(input string tag, input int exp_stall);
        int n = 0;
        bit done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (mem_stall) n++;
            else done = 1'b1;
            mem_respond();
            if (!done) @(negedge clk);
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        int wr_before;
        rst_n = 1'b0;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 512; i++) mem[i] = DW'(i * 7 + 3);
        mem[9'h010] = 16'hBEEF;
        mem[9'h1FF] = 16'h00AA;
        mem[9'h020] = 16'h5A5A;
        #12;
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_stall", 32'(mem_stall), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_p0_rdata", 32'(p0_rdata), 32'd0);
        check_eq("rst_p1_rdata", 32'(p1_rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // P1 load alone
        drive(0, 0, '0, '0, 1, 0, 9'h1FF, '0);
        push(0, 9'h1FF, '0);
        run_pair("t3", 3);
        check_eq("t3_p1_rdata", 32'(p1_rdata), 32'h00AA);
        check_eq("t3_p0_rdata", 32'(p0_rdata), 32'h0);

        // P0 load alone, minimum latency
        drive(1, 0, 9'h010, '0, 0, 0, '0, '0);
        push(0, 9'h010, '0);
        run_pair("t1", 3);
        check_eq("t1_p0_rdata", 32'(p0_rdata), 32'hBEEF);
        check_eq("t1_p1_rdata", 32'(p1_rdata), 32'h00AA);

        // P0 store then P1 load to the same address
        drive(1, 1, 9'h005, 16'h1234, 1, 0, 9'h005, '0);
        push(1, 9'h005, 16'h1234);
        push(0, 9'h005, '0);
        run_pair("t2", 4);
        check_eq("t2_p1_rdata", 32'(p1_rdata), 32'h1234);
        check_eq("t2_p0_rdata", 32'(p0_rdata), 32'hBEEF);
        check_eq("t2_mem", 32'(mem[9'h005]), 32'h1234);

        // P0 store with grant withheld for 3 cycles
        wr_before = wr_cnt;
        gnt_hold  = 3;
        drive(1, 1, 9'h0A0, 16'h7777, 0, 0, '0, '0);
        push(1, 9'h0A0, 16'h7777);
        run_pair("t4", 5);
        check_eq("t4_writes", 32'(wr_cnt - wr_before), 32'd1);
        check_eq("t4_mem", 32'(mem[9'h0A0]), 32'h7777);
        check_eq("t4_p0_rdata", 32'(p0_rdata), 32'hBEEF);

        // Stray rvalid while idle
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        #1;
        check_eq("t6_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check_eq("t6_p0_rdata", 32'(p0_rdata), 32'hBEEF);
        check_eq("t6_p1_rdata", 32'(p1_rdata), 32'h1234);

        // Reset while waiting for read data
        @(negedge clk);
        drive(1, 0, 9'h020, '0, 0, 0, '0, '0);
        push(0, 9'h020, '0);
        #1;
        mem_respond();
        @(negedge clk);
        #1;
        mem_respond();
        check_eq("t5_gnt", 32'(mem_gnt), 32'd1);
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check_eq("t5_wt0_stall", 32'(mem_stall), 32'd1);
        rst_n = 1'b0;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        #1;
        check_eq("t5_rst_req", 32'(mem_req), 32'd0);
        check_eq("t5_rst_stall", 32'(mem_stall), 32'd0);
        check_eq("t5_rst_p0_rdata", 32'(p0_rdata), 32'd0);
        check_eq("t5_rst_p1_rdata", 32'(p1_rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        mem_respond();
        check_eq("t5_late_rvalid", 32'(mem_rvalid), 32'd1);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check_eq("t5_late_p0_rdata", 32'(p0_rdata), 32'd0);
        check_eq("t5_late_stall", 32'(mem_stall), 32'd0);
        check_eq("t5_late_req", 32'(mem_req), 32'd0);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
